// File: rtl/wb_arb_rr_timeout_pkg.sv
// Shared types for the round-robin Wishbone arbiter with slave-timeout abort.
// Holds the FSM encoding and a width helper for the counters.
package wb_arb_rr_timeout_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_ABORT} wb_arb_state_t;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/wb_arb_rr_timeout_if.sv
// Master-side and slave-mux-side Wishbone signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is its environment.
interface wb_arb_rr_timeout_if #(
  parameter int NUM_MASTERS  = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i;
  logic [DATA_WIDTH-1:0]               m_dat_o;
  logic [NUM_MASTERS-1:0]              m_we_i;
  logic [NUM_MASTERS*SELECT_WIDTH-1:0] m_sel_i;
  logic [NUM_MASTERS-1:0]              m_stb_i;
  logic [NUM_MASTERS-1:0]              m_cyc_i;
  logic [NUM_MASTERS-1:0]              m_ack_o;
  logic [NUM_MASTERS-1:0]              m_err_o;
  logic [NUM_MASTERS-1:0]              m_stall_o;
  logic [ADDR_WIDTH-1:0]               s_adr_o;
  logic [DATA_WIDTH-1:0]               s_dat_o;
  logic                                s_we_o;
  logic [SELECT_WIDTH-1:0]             s_sel_o;
  logic                                s_stb_o;
  logic                                s_cyc_o;
  logic [DATA_WIDTH-1:0]               s_dat_i;
  logic                                s_ack_i;
  logic                                s_err_i;
  logic                                s_stall_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
           s_dat_i, s_ack_i, s_err_i, s_stall_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o,
           s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_we_i, m_sel_i, m_stb_i, m_cyc_i,
           s_dat_i, s_ack_i, s_err_i, s_stall_i,
    input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
           s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o
  );
endinterface

// File: rtl/wb_arb_rr_timeout_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping,
// with `last` itself lowest priority. Zero latency, no backpressure.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(last) + i) % N);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/wb_arb_rr_timeout.sv
// Round-robin Wishbone B4 pipelined arbiter; grant registered one cycle after cyc, held for the whole cycle.
// Stalls the owner at MAX_OUTSTANDING or on slave stall; aborts with ERR after TIMEOUT_CYCLES of silence.
module wb_arb_rr_timeout
  import wb_arb_rr_timeout_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wb_arb_rr_timeout_if.slave     bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int OW = cnt_width(MAX_OUTSTANDING);
  localparam int TW = cnt_width(TIMEOUT_CYCLES - 1);
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  wb_arb_state_t          state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d, last_q, last_d, pick_idx;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pick_gnt;
  logic [OW-1:0]          outst_q, outst_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   abort_q, abort_d;

  logic                   own_cyc, own_stb, full, outst_nz, resp, accept, retire;
  logic                   s_cyc, s_stb;
  logic [NUM_MASTERS-1:0] m_ack, m_err, m_stall;

  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req  (bus.m_cyc_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  assign own_cyc  = bus.m_cyc_i[owner_q];
  assign own_stb  = bus.m_stb_i[owner_q];
  assign full     = (outst_q == OUT_MAX);
  assign outst_nz = (outst_q != '0);
  assign resp     = bus.s_ack_i | bus.s_err_i;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    outst_d = outst_q;
    timer_d = '0;
    abort_d = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m_ack   = '0;
    m_err   = '0;
    m_stall = '1;
    accept  = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        outst_d = '0;
        if (|bus.m_cyc_i) begin
          owner_d = pick_idx;
          gnt_d   = pick_gnt;
          state_d = ARB_OWN;
        end
      end
      ARB_OWN: begin
        s_cyc            = own_cyc;
        s_stb            = own_stb & ~full;
        m_stall[owner_q] = bus.s_stall_i | full;
        // Responses with nothing outstanding are spurious and swallowed.
        m_ack[owner_q]   = bus.s_ack_i & outst_nz;
        m_err[owner_q]   = bus.s_err_i & outst_nz;
        accept           = s_stb & ~bus.s_stall_i;
        retire           = resp & outst_nz;
        if (!own_cyc) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
          outst_d = '0;
        end else if (outst_nz && !resp && timer_q == TMO_LAST) begin
          state_d = ARB_ABORT;
          outst_d = '0;
          abort_d = 1'b1;
        end else begin
          if (accept && !retire)      outst_d = outst_q + OW'(1);
          else if (!accept && retire) outst_d = outst_q - OW'(1);
          if (outst_nz && !resp)      timer_d = timer_q + TW'(1);
        end
      end
      ARB_ABORT: begin
        m_err[owner_q] = abort_q;
        if (!own_cyc) begin
          state_d = ARB_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      gnt_q   <= '0;
      outst_q <= '0;
      timer_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      outst_q <= outst_d;
      timer_q <= timer_d;
      abort_q <= abort_d;
    end
  end

  assign grant_o       = (state_q == ARB_IDLE) ? '0 : gnt_q;
  assign timeout_o     = abort_q;
  assign bus.m_dat_o   = bus.s_dat_i;
  assign bus.m_ack_o   = m_ack;
  assign bus.m_err_o   = m_err;
  assign bus.m_stall_o = m_stall;
  assign bus.s_cyc_o   = s_cyc;
  assign bus.s_stb_o   = s_stb;
  assign bus.s_adr_o   = bus.m_adr_i[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.s_dat_o   = bus.m_dat_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.s_sel_o   = bus.m_sel_i[int'(owner_q)*SELECT_WIDTH +: SELECT_WIDTH];
  assign bus.s_we_o    = bus.m_we_i[owner_q];
endmodule
